// File: rtl/regfile_mp.sv
// Multi-port integer register file: combinational reads, two prioritised
// synchronous write ports, optional write-to-read bypass and a pending scoreboard.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr0_en,
  input  logic [AW-1:0]           wr0_addr,
  input  logic [XLEN-1:0]         wr0_data,
  input  logic                    wr1_en,
  input  logic [AW-1:0]           wr1_addr,
  input  logic [XLEN-1:0]         wr1_data,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_addr,
  output logic [AW:0]             busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic          w0Ok, w1Ok, allocOk;
  logic [AW-1:0] ra;
  logic          hit0, hit1;

  // Writable/readable register: inside the array and not the hardwired zero.
  function automatic logic addrOk(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w0Ok    = !rst && wr0_en   && addrOk(wr0_addr);
  assign w1Ok    = !rst && wr1_en   && addrOk(wr1_addr);
  assign allocOk = !rst && alloc_en && addrOk(alloc_addr);

  // Alloc is applied after the clears so a new producer in flight keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if ((w0Ok && wr0_addr == AW'(i)) || (w1Ok && wr1_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (allocOk && alloc_addr == AW'(i)) begin
        busy_d[i] = 1'b1;
      end
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w0Ok) begin
        regs_q[wr0_addr] <= wr0_data;
      end
      if (w1Ok) begin
        regs_q[wr1_addr] <= wr1_data;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Port 1 outranks port 0 on bypass, mirroring the write priority.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      ra   = rd_addr[k*AW +: AW];
      hit0 = (BYPASS != 0) && w0Ok && (wr0_addr == ra);
      hit1 = (BYPASS != 0) && w1Ok && (wr1_addr == ra);
      if (addrOk(ra)) begin
        if (hit1) begin
          rd_data[k*XLEN +: XLEN] = wr1_data;
        end else if (hit0) begin
          rd_data[k*XLEN +: XLEN] = wr0_data;
        end else begin
          rd_data[k*XLEN +: XLEN] = regs_q[ra];
        end
        rd_busy[k] = busy_q[ra] && !(hit0 || hit1);
      end
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one default instance (bypass, zero reg) and one
// 24-entry, 3-read, no-bypass, no-zero-reg instance checked against a reference model.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int BNREGS = 24;

  logic clk = 1'b0;
  logic rst;

  logic [2*AW-1:0]   aRdAddr;
  logic [2*XLEN-1:0] aRdData;
  logic [1:0]        aRdBusy;
  logic              aWr0En, aWr1En, aAllocEn;
  logic [AW-1:0]     aWr0Addr, aWr1Addr, aAllocAddr;
  logic [XLEN-1:0]   aWr0Data, aWr1Data;
  logic [AW:0]       aBusyCnt;

  logic [3*AW-1:0]   bRdAddr;
  logic [3*XLEN-1:0] bRdData;
  logic [2:0]        bRdBusy;
  logic              bWr0En, bWr1En, bAllocEn;
  logic [AW-1:0]     bWr0Addr, bWr1Addr, bAllocAddr;
  logic [XLEN-1:0]   bWr0Data, bWr1Data;
  logic [AW:0]       bBusyCnt;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dutA (
    .clk(clk), .rst(rst),
    .rd_addr(aRdAddr), .rd_data(aRdData), .rd_busy(aRdBusy),
    .wr0_en(aWr0En), .wr0_addr(aWr0Addr), .wr0_data(aWr0Data),
    .wr1_en(aWr1En), .wr1_addr(aWr1Addr), .wr1_data(aWr1Data),
    .alloc_en(aAllocEn), .alloc_addr(aAllocAddr), .busy_cnt(aBusyCnt)
  );

  regfile_mp #(.XLEN(32), .NREGS(BNREGS), .NREAD(3), .BYPASS(0), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst),
    .rd_addr(bRdAddr), .rd_data(bRdData), .rd_busy(bRdBusy),
    .wr0_en(bWr0En), .wr0_addr(bWr0Addr), .wr0_data(bWr0Data),
    .wr1_en(bWr1En), .wr1_addr(bWr1Addr), .wr1_data(bWr1Data),
    .alloc_en(bAllocEn), .alloc_addr(bAllocAddr), .busy_cnt(bBusyCnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = read data, 1 = read busy, 2 = busy count
  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } expT;

  expT sbQ[$];
  int  testsRun    = 0;
  int  testsFailed = 0;

  logic [XLEN-1:0] bMem [BNREGS];
  bit              bBusyM [BNREGS];
  int              bCntM;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int dut, input int kind, input int port,
                         input logic [31:0] exp, input string name);
    expT e;
    e.dut  = dut;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic expA(input int port, input logic [31:0] data, input logic busy, input string name);
    pushExp(0, 0, port, data, {name, "_data"});
    pushExp(0, 1, port, {31'b0, busy}, {name, "_busy"});
  endtask

  task automatic expB(input int port, input logic [31:0] data, input logic busy, input string name);
    pushExp(1, 0, port, data, {name, "_data"});
    pushExp(1, 1, port, {31'b0, busy}, {name, "_busy"});
  endtask

  task automatic applyStimulus(input logic w0e, input logic [AW-1:0] w0a, input logic [31:0] w0d,
                               input logic w1e, input logic [AW-1:0] w1a, input logic [31:0] w1d,
                               input logic ae, input logic [AW-1:0] aa,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    aWr0En = w0e; aWr0Addr = w0a; aWr0Data = w0d;
    aWr1En = w1e; aWr1Addr = w1a; aWr1Data = w1d;
    aAllocEn = ae; aAllocAddr = aa;
    aRdAddr = {r1, r0};
  endtask

  task automatic driveB(input logic w0e, input logic [AW-1:0] w0a, input logic [31:0] w0d,
                        input logic w1e, input logic [AW-1:0] w1a, input logic [31:0] w1d,
                        input logic ae, input logic [AW-1:0] aa,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bWr0En = w0e; bWr0Addr = w0a; bWr0Data = w0d;
    bWr1En = w1e; bWr1Addr = w1a; bWr1Data = w1d;
    bAllocEn = ae; bAllocAddr = aa;
    bRdAddr = {r2, r1, r0};
  endtask

  function automatic logic [31:0] sampleOut(input expT e);
    if (e.dut == 0) begin
      case (e.kind)
        0:       return aRdData[e.port*XLEN +: XLEN];
        1:       return {31'b0, aRdBusy[e.port]};
        default: return 32'(aBusyCnt);
      endcase
    end
    case (e.kind)
      0:       return bRdData[e.port*XLEN +: XLEN];
      1:       return {31'b0, bRdBusy[e.port]};
      default: return 32'(bBusyCnt);
    endcase
  endfunction

  task automatic checkOutput(input expT e);
    logic [31:0] got;
    got = sampleOut(e);
    testsRun++;
    if (got !== e.exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, got, e.exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so everything queued this cycle is checked here.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      checkOutput(sbQ.pop_front());
    end
  end

  initial begin
    logic          w0e, w1e, ae;
    logic [AW-1:0] a0, a1, aa;
    logic [31:0]   d0, d1;
    logic [AW-1:0] rds [3];
    logic [31:0]   expData;
    logic          expBusy;
    bit            aOk, w0Ok, w1Ok;

    // Reset with a competing write: reset must win.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 5, 32'h1234_5678, 0, 0, 5, 0);
    driveB(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    expA(0, 32'h0, 1'b0, "rst_rd5");
    expA(1, 32'h0, 1'b0, "rst_rd0");
    pushExp(0, 2, 0, 32'd0, "rst_cntA");
    driveB(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 23);
    expB(0, 32'h0, 1'b0, "rst_b5");
    expB(2, 32'h0, 1'b0, "rst_b23");
    pushExp(1, 2, 0, 32'd0, "rst_cntB");
    tick();

    // Same-address dual write: port 1 wins, also through the bypass.
    applyStimulus(1, 3, 32'hAAAA_0000, 1, 3, 32'h0000_5555, 0, 0, 3, 4);
    expA(0, 32'h0000_5555, 1'b0, "prio_bypass");
    expA(1, 32'h0, 1'b0, "prio_other");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    expA(0, 32'h0000_5555, 1'b0, "prio_stored");
    tick();

    // Hardwired zero register ignores write and alloc.
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 3);
    expA(0, 32'h0, 1'b0, "zero_bypass");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    expA(0, 32'h0, 1'b0, "zero_stored");
    pushExp(0, 2, 0, 32'd0, "zero_cnt");
    tick();

    // Scoreboard lifecycle on register 7.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    expA(0, 32'h0, 1'b0, "life_alloc_same_cycle");
    pushExp(0, 2, 0, 32'd0, "life_cnt0");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    expA(0, 32'h0, 1'b1, "life_busy");
    pushExp(0, 2, 0, 32'd1, "life_cnt1");
    tick();
    applyStimulus(1, 7, 32'h1111_1111, 0, 0, 0, 1, 7, 7, 0);
    expA(0, 32'h1111_1111, 1'b0, "life_wr_alloc_bypass");
    pushExp(0, 2, 0, 32'd1, "life_realloc_cnt");
    tick();
    applyStimulus(0, 0, 0, 1, 7, 32'h7777_7777, 0, 0, 7, 0);
    expA(0, 32'h7777_7777, 1'b0, "life_wb_bypass");
    pushExp(0, 2, 0, 32'd1, "life_alloc_won");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    expA(0, 32'h7777_7777, 1'b0, "life_done");
    pushExp(0, 2, 0, 32'd0, "life_cnt_done");
    tick();

    // Two distinct busy registers cleared in one cycle.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 2, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 2, 9);
    expA(0, 32'h0, 1'b1, "dual_busy2");
    expA(1, 32'h0, 1'b0, "dual_busy9_pre");
    pushExp(0, 2, 0, 32'd1, "dual_cnt1");
    tick();
    applyStimulus(1, 2, 32'h0000_0022, 1, 9, 32'h0000_0099, 0, 0, 2, 9);
    expA(0, 32'h0000_0022, 1'b0, "dual_wb2");
    expA(1, 32'h0000_0099, 1'b0, "dual_wb9");
    pushExp(0, 2, 0, 32'd2, "dual_cnt2");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
    expA(0, 32'h0000_0022, 1'b0, "dual_after2");
    expA(1, 32'h0000_0099, 1'b0, "dual_after9");
    pushExp(0, 2, 0, 32'd0, "dual_cnt0");
    tick();

    // Instance B: register 0 is ordinary, no bypass, entries 24..31 do not exist.
    driveB(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 30, 1);
    expB(0, 32'h0, 1'b0, "b_nobypass");
    expB(1, 32'h0, 1'b0, "b_inv_idle");
    tick();
    driveB(0, 0, 0, 1, 30, 32'hDEAD_BEEF, 1, 30, 0, 30, 23);
    expB(0, 32'hFFFF_FFFF, 1'b0, "b_reg0_written");
    expB(1, 32'h0, 1'b0, "b_inv_wr_cycle");
    tick();
    driveB(0, 0, 0, 0, 0, 0, 1, 0, 30, 0, 31);
    expB(0, 32'h0, 1'b0, "b_inv_rd");
    pushExp(1, 2, 0, 32'd0, "b_inv_cnt");
    tick();
    driveB(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 30, 31);
    expB(0, 32'hFFFF_FFFF, 1'b1, "b_reg0_busy");
    pushExp(1, 2, 0, 32'd1, "b_reg0_cnt");
    tick();
    driveB(0, 0, 0, 0, 0, 0, 0, 0, 0, 30, 31);
    expB(0, 32'hFFFF_FFFF, 1'b0, "b_reg0_clear");
    pushExp(1, 2, 0, 32'd0, "b_reg0_cnt0");
    tick();

    // Random traffic on B against a rule-based reference model.
    for (int i = 0; i < BNREGS; i++) begin
      bMem[i]   = '0;
      bBusyM[i] = 1'b0;
    end
    bMem[0] = 32'hFFFF_FFFF;
    bCntM   = 0;
    for (int c = 0; c < 2000; c++) begin
      w0e = 1'($urandom_range(0, 1));
      w1e = 1'($urandom_range(0, 1));
      ae  = 1'($urandom_range(0, 1));
      a0  = AW'($urandom_range(0, 31));
      a1  = AW'($urandom_range(0, 31));
      aa  = AW'($urandom_range(0, 31));
      d0  = $urandom;
      d1  = $urandom;
      for (int k = 0; k < 3; k++) begin
        rds[k] = AW'($urandom_range(0, 31));
      end
      driveB(w0e, a0, d0, w1e, a1, d1, ae, aa, rds[0], rds[1], rds[2]);
      for (int k = 0; k < 3; k++) begin
        expData = '0;
        expBusy = 1'b0;
        if (int'(rds[k]) < BNREGS) begin
          expData = bMem[rds[k]];
          expBusy = bBusyM[rds[k]];
        end
        expB(k, expData, expBusy, $sformatf("rand%0d_p%0d", c, k));
      end
      pushExp(1, 2, 0, 32'(bCntM), $sformatf("rand%0d_cnt", c));

      aOk  = ae  && (int'(aa) < BNREGS);
      w0Ok = w0e && (int'(a0) < BNREGS);
      w1Ok = w1e && (int'(a1) < BNREGS);
      if (w0Ok) bMem[a0] = d0;
      if (w1Ok) bMem[a1] = d1;
      if (w0Ok && bBusyM[a0] && !(aOk && aa == a0)) begin
        bBusyM[a0] = 1'b0;
        bCntM--;
      end
      if (w1Ok && bBusyM[a1] && !(aOk && aa == a1)) begin
        bBusyM[a1] = 1'b0;
        bCntM--;
      end
      if (aOk && !bBusyM[aa]) begin
        bBusyM[aa] = 1'b1;
        bCntM++;
      end
      tick();
    end

    driveB(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
